count_monitor: RTL and testbench
================================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WRAP_W, default 8: width of the wrap counter and of the event payload; legal range 2..16.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port clr, input, 1: reset, synchronous and active-high.
REQ-004 Port sample, input, 1: q_in is valid this cycle and shall be evaluated.
REQ-005 Port q_in, input, 3: count value from the upstream 3-bit synchronous counter.
REQ-006 Port ev_ready, input, 1: downstream accepts the wrap event.
REQ-007 Port q_reg, output, 3: last accepted count value.
REQ-008 Port rollover, output, 1: one-cycle pulse on a 7->0 step.
REQ-009 Port wrap_cnt, output, WRAP_W: number of rollovers since reset; saturates at all-ones.
REQ-010 Port ev_valid, output, 1: wrap event pending.
REQ-011 Port ev_data, output, WRAP_W: wrap_cnt value carried by the pending event.
REQ-012 Port ev_ovf, output, 1: sticky flag; an unaccepted event was overwritten.
REQ-013 Port step_err, output, 1: sticky flag; an illegal count step was detected.
REQ-014 Port state, output, 2: FSM encoding; IDLE=0, TRACK=1, ERR=2.

Function
REQ-015 The FSM shall be in IDLE after reset; in IDLE, sample=1 loads q_reg<=q_in and moves to TRACK with no rollover.
REQ-016 In TRACK with sample=1 and q_in==q_reg, the block shall hold all state and generate no event.
REQ-017 In TRACK with sample=1 and q_in==(q_reg+1) mod 8, the block shall load q_reg<=q_in.
REQ-018 If that step is 7->0, the block shall:
- pulse rollover for exactly one cycle after the sampling edge;
- increment wrap_cnt, saturating at 2^WRAP_W-1;
- set ev_valid=1 with ev_data equal to the new wrap_cnt.
REQ-019 Any other q_in value under sample=1 in TRACK is an illegal step; behaviour is governed by REQ-027 and REQ-028.
REQ-020 sample=0 shall change no state; rollover shall be 0 in that cycle.
REQ-021 The event handshake shall behave as follows:
- ev_valid stays 1 with ev_data stable until ev_valid and ev_ready are both 1 on a clock edge;
- acceptance clears ev_valid on that edge.
REQ-022 If a new rollover occurs while ev_valid=1 and the event is not accepted on that edge, ev_data shall take the new value, ev_valid shall stay 1, and ev_ovf shall be set.
REQ-023 If a new rollover coincides with acceptance, ev_valid shall stay 1 with the new ev_data and ev_ovf shall remain unchanged.
REQ-024 Once wrap_cnt is saturated, further rollovers shall still pulse rollover and raise events, with ev_data equal to all-ones.

Reset
REQ-025 When clr=1 at a rising edge, the block shall reset regardless of sample, ev_ready or FSM state:
- state=IDLE;
- q_reg=0, wrap_cnt=0, ev_data=0;
- rollover=0, ev_valid=0, ev_ovf=0, step_err=0.
REQ-026 clr shall take priority over a simultaneous sample, rollover or handshake; a pending event is dropped.

Configuration
REQ-027 With COUNT_MON_STEP_CHECK_EN defined, an illegal step shall:
- set step_err and move to ERR;
- leave q_reg unchanged.
In ERR, all samples shall be ignored, ev_ready handshaking of an already pending event shall still complete, and only clr exits ERR.
REQ-028 Without COUNT_MON_STEP_CHECK_EN:
- an illegal step shall resynchronise q_reg<=q_in and stay in TRACK with no rollover;
- step_err shall be tied to 0;
- ERR shall be unreachable.

Structure
REQ-029 Package count_mon_pkg shall hold:
- the state enum/constants (IDLE, TRACK, ERR);
- the count width constant CNT_W=3;
- the maximum count constant CNT_MAX=7.
REQ-030 The saturating wrap counter, with its event register and ev_ovf logic, shall be the sub-module wrap_event_reg; the FSM and step check shall stay in count_monitor.

Verification
REQ-031 After reset, sample q_in 0,1,...,7,0 on consecutive cycles with ev_ready=0 -> one rollover pulse, wrap_cnt=1, ev_valid=1, ev_data=1.
REQ-032 With an event pending, hold ev_ready=0 and force a second 7->0 -> ev_data=2, ev_valid=1, ev_ovf=1; then ev_ready=1 for one cycle -> ev_valid=0.
REQ-033 With WRAP_W=2, drive 5 full wraps while ev_ready=1 -> wrap_cnt sequence 1,2,3,3,3 and 5 rollover pulses.
REQ-034 In TRACK at q_reg=2, sample q_in=5:
- with COUNT_MON_STEP_CHECK_EN -> step_err=1, state=ERR, q_reg=2, later samples ignored;
- without it -> q_reg=5, state=TRACK.
REQ-035 Assert clr on the same edge as a 7->0 sample with ev_valid=1 -> all outputs at reset values, no rollover pulse.
REQ-036 Repeat q_in=3 five times, then sample=0 with q_in=4 -> q_reg=3 throughout, no events.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count monitor: FSM state encoding,
// the width and terminal value of the upstream 3-bit counter, and the
// modulo-8 successor used by the step check.
package count_mon_pkg;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    // Legal successor of a count value; wraps 7 -> 0 through truncation.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] q);
        return q + CNT_W'(1);
    endfunction

endpackage

// File: rtl/wrap_event_reg.sv
// Saturating rollover counter plus a single-entry event register with a
// valid/ready handshake. A rollover arriving while an event is still
// pending overwrites the payload and raises a sticky overflow flag, unless
// the pending event is accepted on that same edge.
module wrap_event_reg #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_wrap,
    input  logic              i_ev_ready,
    output logic [WRAP_W-1:0] o_wrap_cnt,
    output logic              o_ev_valid,
    output logic [WRAP_W-1:0] o_ev_data,
    output logic              o_ev_ovf
);

    logic [WRAP_W-1:0] r_wrap_cnt;
    logic [WRAP_W-1:0] r_ev_data;
    logic              r_ev_valid;
    logic              r_ev_ovf;

    logic [WRAP_W-1:0] w_cnt_next;
    logic              w_accept;

    // Hold at all-ones once saturated; later events carry the saturated value.
    assign w_cnt_next = (&r_wrap_cnt) ? r_wrap_cnt : r_wrap_cnt + WRAP_W'(1);
    assign w_accept   = r_ev_valid & i_ev_ready;

    // Counter, event payload, handshake and overflow tracking.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wrap_cnt <= '0;
            r_ev_data  <= '0;
            r_ev_valid <= 1'b0;
            r_ev_ovf   <= 1'b0;
        end else if (i_wrap) begin
            r_wrap_cnt <= w_cnt_next;
            r_ev_data  <= w_cnt_next;
            r_ev_valid <= 1'b1;
            if (r_ev_valid && !i_ev_ready) begin
                r_ev_ovf <= 1'b1;
            end
        end else if (w_accept) begin
            r_ev_valid <= 1'b0;
        end
    end

    assign o_wrap_cnt = r_wrap_cnt;
    assign o_ev_valid = r_ev_valid;
    assign o_ev_data  = r_ev_data;
    assign o_ev_ovf   = r_ev_ovf;

endmodule

// File: rtl/count_monitor.sv
// Monitors a free-running 3-bit counter: tracks its value, flags 7->0
// rollovers as one-cycle pulses and handshaked events.
//
// Build option COUNT_MON_STEP_CHECK_EN: when defined, an illegal step
// (neither hold nor +1) latches step_err and parks the FSM in ERR until
// clr. When undefined, an illegal step just resynchronises q_reg.
//
// state | meaning
// IDLE  | no reference value yet; first sample loads q_reg
// TRACK | following the counter, checking each sampled step
// ERR   | illegal step seen; samples ignored until clr
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              sample,
    input  logic [CNT_W-1:0]  q_in,
    input  logic              ev_ready,
    output logic [CNT_W-1:0]  q_reg,
    output logic              rollover,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              ev_valid,
    output logic [WRAP_W-1:0] ev_data,
    output logic              ev_ovf,
    output logic              step_err,
    output logic [1:0]        state
);

    state_t           r_state;
    logic [CNT_W-1:0] r_q_reg;
    logic             r_rollover;

    logic w_track_smp;
    logic w_step_hold;
    logic w_step_inc;
    logic w_wrap;

    assign w_track_smp = (r_state == TRACK) && sample;
    assign w_step_hold = (q_in == r_q_reg);
    assign w_step_inc  = (q_in == next_count(r_q_reg));
    assign w_wrap      = w_track_smp && w_step_inc && (r_q_reg == CNT_MAX);

`ifdef COUNT_MON_STEP_CHECK_EN
    logic r_step_err;
`endif

    // FSM with step check; rollover is registered so it appears as a pulse
    // in the cycle after the sampling edge, aligned with the wrap count update.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_q_reg    <= '0;
            r_rollover <= 1'b0;
`ifdef COUNT_MON_STEP_CHECK_EN
            r_step_err <= 1'b0;
`endif
        end else begin
            r_rollover <= w_wrap;
            case (r_state)
                IDLE: begin
                    if (sample) begin
                        r_q_reg <= q_in;
                        r_state <= TRACK;
                    end
                end
                TRACK: begin
                    if (sample && !w_step_hold) begin
                        if (w_step_inc) begin
                            r_q_reg <= q_in;
                        end else begin
`ifdef COUNT_MON_STEP_CHECK_EN
                            r_step_err <= 1'b1;
                            r_state    <= ERR;
`else
                            r_q_reg <= q_in;
`endif
                        end
                    end
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    wrap_event_reg #(
        .WRAP_W(WRAP_W)
    ) u_wrap_event_reg (
        .clk        (clk),
        .clr        (clr),
        .i_wrap     (w_wrap),
        .i_ev_ready (ev_ready),
        .o_wrap_cnt (wrap_cnt),
        .o_ev_valid (ev_valid),
        .o_ev_data  (ev_data),
        .o_ev_ovf   (ev_ovf)
    );

    assign q_reg    = r_q_reg;
    assign rollover = r_rollover;
    assign state    = r_state;
`ifdef COUNT_MON_STEP_CHECK_EN
    assign step_err = r_step_err;
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: two instances (WRAP_W=8 and WRAP_W=2) share one
// stimulus stream; a behavioural model counts rollovers as plain integers
// and saturates per width when comparing.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       clr, sample, ev_ready;
    logic [2:0] q_in;

    logic [2:0] q8, q2;
    logic       ro8, ro2, ev8, ev2, ovf8, ovf2, err8, err2;
    logic [7:0] wc8, ed8;
    logic [1:0] wc2, ed2;
    logic [1:0] st8, st2;

    count_monitor dut8 (
        .clk(clk), .clr(clr), .sample(sample), .q_in(q_in), .ev_ready(ev_ready),
        .q_reg(q8), .rollover(ro8), .wrap_cnt(wc8), .ev_valid(ev8), .ev_data(ed8),
        .ev_ovf(ovf8), .step_err(err8), .state(st8)
    );

    count_monitor #(.WRAP_W(2)) dut2 (
        .clk(clk), .clr(clr), .sample(sample), .q_in(q_in), .ev_ready(ev_ready),
        .q_reg(q2), .rollover(ro2), .wrap_cnt(wc2), .ev_valid(ev2), .ev_data(ed2),
        .ev_ovf(ovf2), .step_err(err2), .state(st2)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_roll8 = 0;
    int n_roll2 = 0;
    bit chk_en = 1'b0;

    // model state
    int m_state = 0;
    int m_q = 0;
    int m_wraps = 0;
    int m_pend = 0;
    int m_pwr = 0;
    int m_ovf = 0;
    int m_err = 0;
    int m_roll = 0;
    int m_wrap_now;

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Behavioural model: one update per rising edge from the applied inputs.
    always @(posedge clk) begin
        if (clr) begin
            m_state = 0; m_q = 0; m_wraps = 0; m_pend = 0;
            m_pwr = 0; m_ovf = 0; m_err = 0; m_roll = 0;
        end else begin
            m_wrap_now = 0;
            if (sample) begin
                if (m_state == 0) begin
                    m_q = int'(q_in);
                    m_state = 1;
                end else if (m_state == 1) begin
                    if (int'(q_in) == (m_q + 1) % 8) begin
                        m_wrap_now = (m_q == 7) ? 1 : 0;
                        m_q = int'(q_in);
                    end else if (int'(q_in) != m_q) begin
`ifdef COUNT_MON_STEP_CHECK_EN
                        m_err = 1;
                        m_state = 2;
`else
                        m_q = int'(q_in);
`endif
                    end
                end
            end
            if (m_wrap_now != 0) begin
                m_wraps++;
                if (m_pend != 0 && !ev_ready) m_ovf = 1;
                m_pend = 1;
                m_pwr = m_wraps;
            end else if (m_pend != 0 && ev_ready) begin
                m_pend = 0;
            end
            m_roll = m_wrap_now;
        end
    end

    // Compare both instances against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("dut8.state", st8, m_state);       cmp("dut2.state", st2, m_state);
            cmp("dut8.q_reg", q8, m_q);            cmp("dut2.q_reg", q2, m_q);
            cmp("dut8.rollover", ro8, m_roll);     cmp("dut2.rollover", ro2, m_roll);
            cmp("dut8.wrap_cnt", wc8, sat(m_wraps, 8));
            cmp("dut2.wrap_cnt", wc2, sat(m_wraps, 2));
            cmp("dut8.ev_valid", ev8, m_pend);     cmp("dut2.ev_valid", ev2, m_pend);
            if (m_pend != 0) begin
                cmp("dut8.ev_data", ed8, sat(m_pwr, 8));
                cmp("dut2.ev_data", ed2, sat(m_pwr, 2));
            end
            cmp("dut8.ev_ovf", ovf8, m_ovf);       cmp("dut2.ev_ovf", ovf2, m_ovf);
            cmp("dut8.step_err", err8, m_err);     cmp("dut2.step_err", err2, m_err);
            if (ro8) n_roll8++;
            if (ro2) n_roll2++;
        end
    end

    task automatic drive(input bit c, input bit s, input int q, input bit r);
        clr = c; sample = s; q_in = 3'(q); ev_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic count_up(input int from, input int to, input bit r);
        for (int i = from; i <= to; i++) drive(1'b0, 1'b1, i, r);
    endtask

    int r8, r2;
    int exp2[5] = '{1, 2, 3, 3, 3};

    initial begin
        clr = 1'b0; sample = 1'b0; q_in = 3'd0; ev_ready = 1'b0;
        drive(1, 0, 0, 0);
        chk_en = 1'b1;
        cmp("rst.state", st8, 0);
        cmp("rst.q_reg", q8, 0);
        cmp("rst.wrap_cnt", wc8, 0);
        cmp("rst.ev_valid", ev8, 0);

        // first wrap, event left pending
        r8 = n_roll8;
        count_up(0, 7, 0);
        drive(0, 1, 0, 0);
        cmp("wrap1.rollover", ro8, 1);
        cmp("wrap1.wrap_cnt", wc8, 1);
        cmp("wrap1.ev_valid", ev8, 1);
        cmp("wrap1.ev_data", ed8, 1);
        drive(0, 0, 0, 0);
        cmp("wrap1.rollover_gone", ro8, 0);
        cmp("wrap1.pulses", n_roll8 - r8, 1);

        // second wrap overwrites the pending event
        count_up(1, 7, 0);
        drive(0, 1, 0, 0);
        cmp("ovf.ev_data", ed8, 2);
        cmp("ovf.ev_valid", ev8, 1);
        cmp("ovf.ev_ovf", ovf8, 1);
        drive(0, 0, 0, 1);
        cmp("ovf.accept_valid", ev8, 0);
        cmp("ovf.sticky", ovf8, 1);

        // rollover coinciding with acceptance
        drive(1, 0, 0, 0);
        count_up(0, 7, 0);
        drive(0, 1, 0, 0);
        count_up(1, 7, 0);
        drive(0, 1, 0, 1);
        cmp("coinc.ev_valid", ev8, 1);
        cmp("coinc.ev_data", ed8, 2);
        cmp("coinc.ev_ovf", ovf8, 0);

        // repeated value then idle sample
        drive(1, 0, 0, 0);
        repeat (5) drive(0, 1, 3, 0);
        cmp("hold.q_reg", q8, 3);
        cmp("hold.state", st8, 1);
        drive(0, 0, 4, 0);
        cmp("hold.q_reg_idle", q8, 3);
        cmp("hold.ev_valid", ev8, 0);

        // illegal step 2 -> 5
        drive(1, 0, 0, 0);
        drive(0, 1, 2, 0);
        drive(0, 1, 5, 0);
`ifdef COUNT_MON_STEP_CHECK_EN
        cmp("step.err", err8, 1);
        cmp("step.state", st8, 2);
        cmp("step.q_reg", q8, 2);
        drive(0, 1, 3, 0);
        cmp("step.ignored_q", q8, 2);
        cmp("step.ignored_state", st8, 2);
`else
        cmp("step.err", err8, 0);
        cmp("step.state", st8, 1);
        cmp("step.q_reg", q8, 5);
        drive(0, 1, 6, 0);
        cmp("step.follow_q", q8, 6);
`endif

        // pending event accepted after an illegal step
        drive(1, 0, 0, 0);
        count_up(0, 7, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 3, 0);
        cmp("errhs.pending", ev8, 1);
        drive(0, 0, 0, 1);
        cmp("errhs.accepted", ev8, 0);

        // five wraps with ready held: WRAP_W=2 saturates at 3
        drive(1, 0, 0, 0);
        r2 = n_roll2;
        drive(0, 1, 0, 1);
        for (int w = 0; w < 5; w++) begin
            count_up(1, 7, 1);
            drive(0, 1, 0, 1);
            cmp("sat.wrap_cnt2", wc2, exp2[w]);
            cmp("sat.wrap_cnt8", wc8, w + 1);
        end
        cmp("sat.ev_data2", ed2, 3);
        drive(0, 0, 0, 0);
        cmp("sat.pulses2", n_roll2 - r2, 5);

        // clr on the same edge as a 7->0 with an event pending
        drive(1, 0, 0, 0);
        count_up(0, 7, 0);
        drive(0, 1, 0, 0);
        count_up(1, 7, 0);
        drive(1, 1, 0, 1);
        cmp("clr.rollover", ro8, 0);
        cmp("clr.ev_valid", ev8, 0);
        cmp("clr.wrap_cnt", wc8, 0);
        cmp("clr.ev_data", ed8, 0);
        cmp("clr.ev_ovf", ovf8, 0);
        cmp("clr.state", st8, 0);
        cmp("clr.q_reg", q8, 0);
        cmp("clr.wrap_cnt2", wc2, 0);

        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
